cdr_frame_sync: RTL

Byte/frame synchroniser that sits directly downstream of the CDR core. It consumes the recovered bit stream, meaning the baud strobe and the hard-decision bit. It hunts for a fixed sync word and confirms frame alignment over consecutive frames. Once locked, it delivers aligned payload bytes with a valid strobe and a frame-start marker, and drops lock after repeated sync misses.

---
 rtl/cdr_frame_sync_if.sv | 33 +++
 rtl/cdr_frame_sync.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cdr_frame_sync_if.sv
// cdr_frame_sync_if: bit-stream input and aligned-byte output bundle of the
// CDR frame synchroniser.
//   bit_en       baud strobe from the CDR
//   bit_in       recovered hard-decision bit, qualified by bit_en
//   resync       synchronous force-to-HUNT
//   byte_out     last completed payload byte, MSB = first received bit
//   byte_valid   one-cycle pulse when byte_out updates
//   frame_start  pulse with byte_valid for payload byte 0
//   locked       high in LOCKED
//   state        0 = HUNT, 1 = VERIFY, 2 = LOCKED
//   sync_err_cnt saturating count of sync misses while LOCKED
// master = bit-stream source / byte sink, slave = the synchroniser.
interface cdr_frame_sync_if;
    logic       bit_en;
    logic       bit_in;
    logic       resync;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_start;
    logic       locked;
    logic [1:0] state;
    logic [7:0] sync_err_cnt;

    modport master (
        output bit_en, bit_in, resync,
        input  byte_out, byte_valid, frame_start, locked, state, sync_err_cnt
    );

    modport slave (
        input  bit_en, bit_in, resync,
        output byte_out, byte_valid, frame_start, locked, state, sync_err_cnt
    );
endinterface

// File: rtl/cdr_frame_sync.sv
// cdr_frame_sync: hunts for SYNC_WORD in the recovered bit stream, confirms
// alignment over LOCK_CNT consecutive frames, then delivers aligned payload
// bytes. Drops lock after MISS_MAX consecutive sync misses.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    cdr_frame_sync_if.slave (bit stream in, bytes/status out)
module cdr_frame_sync #(
    parameter logic [15:0] SYNC_WORD   = 16'hF628,
    parameter int unsigned FRAME_BYTES = 8,
    parameter int unsigned LOCK_CNT    = 2,
    parameter int unsigned MISS_MAX    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    cdr_frame_sync_if.slave   bus
);
    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int unsigned PAY_BITS = 8 * FRAME_BYTES;
    localparam logic [8:0]  PAY_LIM  = 9'(PAY_BITS);
    localparam logic [8:0]  CHK_POS  = 9'(PAY_BITS + 15);

    // Only 15 bits of history are stored: the 16th bit of every comparison
    // is the incoming bit itself.
    logic [14:0] sr_q, sr_d;
    logic [8:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  match_cnt_q, match_cnt_d;
    logic [2:0]  miss_cnt_q, miss_cnt_d;
    logic [1:0]  state_q, state_d;
    logic [7:0]  byte_out_q, byte_out_d;
    logic        byte_valid_q, byte_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, locked_d;
    logic [7:0]  sync_err_cnt_q, sync_err_cnt_d;

    logic [15:0] nxt;
    logic        match;
    logic        at_check;
    logic [2:0]  match_inc;
    logic [2:0]  miss_inc;

    assign nxt       = {sr_q, bus.bit_in};
    assign match     = (nxt == SYNC_WORD);
    assign at_check  = (bit_cnt_q == CHK_POS);
    assign match_inc = match_cnt_q + 3'd1;
    assign miss_inc  = miss_cnt_q + 3'd1;

    always_comb begin
        sr_d           = sr_q;
        bit_cnt_d      = bit_cnt_q;
        match_cnt_d    = match_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        state_d        = state_q;
        byte_out_d     = byte_out_q;
        byte_valid_d   = 1'b0;
        frame_start_d  = 1'b0;
        sync_err_cnt_d = sync_err_cnt_q;

        if (bus.resync) begin
            state_d     = ST_HUNT;
            bit_cnt_d   = '0;
            match_cnt_d = '0;
            miss_cnt_d  = '0;
            if (bus.bit_en) sr_d = nxt[14:0];
        end else if (bus.bit_en) begin
            sr_d = nxt[14:0];
            case (state_q)
                ST_HUNT: begin
                    if (match) begin
                        state_d     = ST_VERIFY;
                        bit_cnt_d   = '0;
                        match_cnt_d = 3'd1;
                    end
                end
                ST_VERIFY: begin
                    if (at_check) begin
                        bit_cnt_d = '0;
                        if (match) begin
                            match_cnt_d = match_inc;
                            if (match_inc == 3'(LOCK_CNT)) begin
                                state_d    = ST_LOCKED;
                                miss_cnt_d = '0;
                            end
                        end else begin
                            state_d     = ST_HUNT;
                            match_cnt_d = '0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 9'd1;
                    end
                end
                ST_LOCKED: begin
                    if (bit_cnt_q < PAY_LIM && bit_cnt_q[2:0] == 3'd7) begin
                        byte_out_d    = nxt[7:0];
                        byte_valid_d  = 1'b1;
                        frame_start_d = (bit_cnt_q == 9'd7);
                    end
                    if (at_check) begin
                        bit_cnt_d = '0;
                        if (match) begin
                            miss_cnt_d = '0;
                        end else begin
                            if (sync_err_cnt_q != 8'hFF)
                                sync_err_cnt_d = sync_err_cnt_q + 8'd1;
                            if (miss_inc == 3'(MISS_MAX)) begin
                                state_d     = ST_HUNT;
                                miss_cnt_d  = '0;
                                match_cnt_d = '0;
                            end else begin
                                miss_cnt_d = miss_inc;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 9'd1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q           <= '0;
            bit_cnt_q      <= '0;
            match_cnt_q    <= '0;
            miss_cnt_q     <= '0;
            state_q        <= ST_HUNT;
            byte_out_q     <= '0;
            byte_valid_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            locked_q       <= 1'b0;
            sync_err_cnt_q <= '0;
        end else begin
            sr_q           <= sr_d;
            bit_cnt_q      <= bit_cnt_d;
            match_cnt_q    <= match_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            state_q        <= state_d;
            byte_out_q     <= byte_out_d;
            byte_valid_q   <= byte_valid_d;
            frame_start_q  <= frame_start_d;
            locked_q       <= locked_d;
            sync_err_cnt_q <= sync_err_cnt_d;
        end
    end

    assign bus.byte_out     = byte_out_q;
    assign bus.byte_valid   = byte_valid_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.locked       = locked_q;
    assign bus.state        = state_q;
    assign bus.sync_err_cnt = sync_err_cnt_q;
endmodule
